// File: rtl/heartbeat_monitor_pkg.sv
// ============================================================================
// Module : heartbeat_monitor_pkg
// Brief  : Shared types, default timing and tolerance helper for the heartbeat
//          generator/monitor pair.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package heartbeat_monitor_pkg;

  typedef int unsigned u32;

  localparam u32 c_MODULO_DEFAULT = 32'd12_000_000;
  localparam u32 c_DUTY_DEFAULT   = 32'd600_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } hb_state_e;

  // 33-bit magnitude difference so neither direction can wrap.
  function automatic logic within_tol(input u32 meas, input u32 target, input u32 tol);
    logic [32:0] a;
    logic [32:0] b;
    logic [32:0] d;
    a = {1'b0, meas};
    b = {1'b0, target};
    d = (a >= b) ? (a - b) : (b - a);
    return (d <= {1'b0, tol});
  endfunction

endpackage

`default_nettype wire

// File: rtl/hb_sync_edge.sv
// ============================================================================
// Module : hb_sync_edge
// Brief  : Two-flop synchronizer, optional glitch filter
//          (HEARTBEAT_MON_GLITCH_FILTER_EN) and registered edge detect.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hb_sync_edge #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

`ifdef HEARTBEAT_MON_GLITCH_FILTER_EN
  localparam bit c_FILT_EN = 1'b1;
`else
  localparam bit c_FILT_EN = 1'b0;
`endif

  logic r_sync1;
  logic r_sync2;
  logic r_level;
  logic r_rise;
  logic r_fall;
  logic w_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (c_FILT_EN && (FILT_LEN > 0)) begin : g_filter
      localparam int unsigned c_CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
      logic [c_CNT_W-1:0] r_stab_cnt;
      logic               r_filt;

      // Level flips only after FILT_LEN consecutive cycles at the new value.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stab_cnt <= '0;
          r_filt     <= 1'b0;
        end else if (r_sync2 == r_filt) begin
          r_stab_cnt <= '0;
        end else if (r_stab_cnt == c_CNT_W'(FILT_LEN - 1)) begin
          r_stab_cnt <= '0;
          r_filt     <= r_sync2;
        end else begin
          r_stab_cnt <= r_stab_cnt + 1'b1;
        end
      end

      assign w_src = r_filt;
    end else begin : g_bypass
      assign w_src = r_sync2;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_level <= w_src;
      r_rise  <= w_src & ~r_level;
      r_fall  <= ~w_src & r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/heartbeat_monitor.sv
// ============================================================================
// Module : heartbeat_monitor
// Brief  : Measures period/high time of an incoming heartbeat and reports
//          lock, loss and error count. Glitch filter: HEARTBEAT_MON_GLITCH_FILTER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module heartbeat_monitor
  import heartbeat_monitor_pkg::*;
#(
  parameter u32 MODULO     = c_MODULO_DEFAULT,
  parameter u32 DUTY       = c_DUTY_DEFAULT,
  parameter u32 TOL        = 32'd1_000,
  parameter u32 LOCK_COUNT = 32'd4,
  parameter u32 TIMEOUT    = 32'd24_000_000,
  parameter u32 FILT_LEN   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_heartbeat,
  output logic        o_locked,
  output logic        o_lost,
  output logic        o_meas_valid,
  output logic [31:0] o_period,
  output logic [31:0] o_high_time,
  output logic [15:0] o_err_count
);

  hb_state_e   r_state;
  hb_state_e   w_state_nxt;
  u32          r_per_cnt;
  u32          r_hi_cnt;
  u32          r_high_hold;
  logic        r_fall_seen;
  u32          r_good_cnt;
  u32          w_good_nxt;
  logic [15:0] r_err_count;
  logic        r_meas_valid;
  logic [31:0] r_period;
  logic [31:0] r_high_time;

  logic w_level;
  logic w_rise;
  logic w_fall;
  logic w_timeout;
  logic w_good;
  logic w_eval;
  logic w_err_inc;
  u32   w_period;
  u32   w_high;

  hb_sync_edge #(
    .FILT_LEN (FILT_LEN)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_heartbeat),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_period  = r_per_cnt + 32'd1;
  // Without a fall since the last rise the line stuck high: report the running count.
  assign w_high    = r_fall_seen ? r_high_hold : r_hi_cnt;
  assign w_good    = within_tol(w_period, MODULO, TOL) && within_tol(w_high, DUTY, TOL);
  // Fires on the cycle per_cnt steps onto TIMEOUT; a coincident rise takes precedence.
  assign w_timeout = (r_per_cnt >= (TIMEOUT - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_good_cnt  <= '0;
      r_err_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      if (w_err_inc && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_eval      = 1'b0;
    w_err_inc   = 1'b0;
    case (r_state)
      IDLE, LOST: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_good_nxt  = '0;
        end else if ((r_state == IDLE) && w_timeout) begin
          w_state_nxt = LOST;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          w_eval = 1'b1;
          if (w_good) begin
            w_good_nxt = r_good_cnt + 32'd1;
            if ((r_good_cnt + 32'd1) >= LOCK_COUNT) begin
              w_state_nxt = LOCKED;
            end
          end else begin
            w_good_nxt = '0;
            w_err_inc  = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = LOST;
        end
      end
      LOCKED: begin
        if (w_rise) begin
          w_eval = 1'b1;
          if (!w_good) begin
            w_state_nxt = MEASURE;
            w_good_nxt  = '0;
            w_err_inc   = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = LOST;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_locked = (r_state == LOCKED);
    o_lost   = (r_state == LOST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_high_hold  <= '0;
      r_fall_seen  <= 1'b0;
      r_meas_valid <= 1'b0;
      r_period     <= '0;
      r_high_time  <= '0;
    end else begin
      if (w_rise) begin
        r_per_cnt <= '0;
      end else if (r_per_cnt < TIMEOUT) begin
        r_per_cnt <= r_per_cnt + 32'd1;
      end

      if (w_rise) begin
        r_hi_cnt <= '0;
      end else if (w_level && (r_hi_cnt < TIMEOUT)) begin
        r_hi_cnt <= r_hi_cnt + 32'd1;
      end

      // +1 accounts for the high cycle on which the rise pulse cleared hi_cnt.
      if (w_fall) begin
        r_high_hold <= (r_hi_cnt < TIMEOUT) ? (r_hi_cnt + 32'd1) : TIMEOUT;
        r_fall_seen <= 1'b1;
      end else if (w_rise) begin
        r_fall_seen <= 1'b0;
      end

      r_meas_valid <= w_eval;
      if (w_eval) begin
        r_period    <= w_period;
        r_high_time <= w_high;
      end
    end
  end

  assign o_meas_valid = r_meas_valid;
  assign o_period     = r_period;
  assign o_high_time  = r_high_time;
  assign o_err_count  = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_heartbeat_monitor.sv
// ============================================================================
// Module : tb_heartbeat_monitor
// Brief  : Scoreboard bench for heartbeat_monitor; pulse-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_heartbeat_monitor;

  localparam int c_MODULO  = 100;
  localparam int c_DUTY    = 10;
  localparam int c_TOL     = 2;
  localparam int c_LOCK    = 4;
  localparam int c_TIMEOUT = 200;

  logic        clk;
  logic        rst;
  logic        hb;
  logic        o_locked;
  logic        o_lost;
  logic        o_meas_valid;
  logic [31:0] o_period;
  logic [31:0] o_high_time;
  logic [15:0] o_err_count;

  heartbeat_monitor #(
    .MODULO     (32'd100),
    .DUTY       (32'd10),
    .TOL        (32'd2),
    .LOCK_COUNT (32'd4),
    .TIMEOUT    (32'd200),
    .FILT_LEN   (32'd4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_heartbeat  (hb),
    .o_locked     (o_locked),
    .o_lost       (o_lost),
    .o_meas_valid (o_meas_valid),
    .o_period     (o_period),
    .o_high_time  (o_high_time),
    .o_err_count  (o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi;
    bit locked;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   lost_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Pulse-level model: each rise judges the pulse that just ended.
  bit m_armed  = 0;
  bit m_locked = 0;
  int m_run    = 0;
  int m_err    = 0;
  int prev_per = 0;
  int prev_hi  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  task automatic model_rise();
    exp_t e;
    if (!m_armed) begin
      m_armed  = 1;
      m_run    = 0;
      m_locked = 0;
    end else begin
      if (absd(prev_per, c_MODULO) <= c_TOL && absd(prev_hi, c_DUTY) <= c_TOL) begin
        m_run++;
        if (m_run >= c_LOCK) m_locked = 1;
      end else begin
        m_run    = 0;
        m_locked = 0;
        if (m_err < 65535) m_err++;
      end
      e.per    = prev_per;
      e.hi     = prev_hi;
      e.locked = m_locked;
      e.err    = m_err;
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, o_locked, 0);
    chk({tag, "_lost"}, o_lost, 0);
    chk({tag, "_valid"}, o_meas_valid, 0);
    chk({tag, "_period"}, o_period, 0);
    chk({tag, "_high"}, o_high_time, 0);
    chk({tag, "_err"}, o_err_count, 0);
  endtask

  // One input period starting with a rise; optional 2-cycle glitch and mid-low reset.
  task automatic send_wave(input int per, input int hi, input int glitch_at, input int rst_at);
    bit do_glitch;
`ifdef HEARTBEAT_MON_GLITCH_FILTER_EN
    do_glitch = 0;
`else
    do_glitch = (glitch_at > 0);
`endif
    model_rise();
    prev_per = do_glitch ? glitch_at : per;
    prev_hi  = hi;
    if (per > c_TIMEOUT) begin
      lost_q.push_back(c_TIMEOUT);
      m_armed  = 0;
      m_locked = 0;
    end
    for (int i = 0; i < per; i++) begin
      hb = (i < hi) || (glitch_at > 0 && (i == glitch_at || i == glitch_at + 1));
      if (do_glitch && i == glitch_at) begin
        model_rise();
        prev_per = per - glitch_at;
        prev_hi  = 2;
      end
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        chk("midrst_queue_empty", exp_q.size(), 0);
        m_armed  = 0;
        m_locked = 0;
        m_run    = 0;
        m_err    = 0;
        @(negedge clk);
        rst = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic ideal(input int n);
    for (int k = 0; k < n; k++) send_wave(c_MODULO, c_DUTY, -1, -1);
  endtask

  int cyc = 0;
  int last_valid_cyc = 0;
  bit prev_lost = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      prev_lost = 0;
    end else begin
      if (o_meas_valid) begin
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("period", o_period, e.per);
          chk("high_time", o_high_time, e.hi);
          chk("locked_at_valid", o_locked, e.locked);
          chk("err_count", o_err_count, e.err);
          chk("lost_at_valid", o_lost, 0);
        end
      end
      if (o_lost && !prev_lost) begin
        if (lost_q.size() == 0) begin
          chk("unexpected_lost", 1, 0);
        end else begin
          chk("lost_delay", cyc - last_valid_cyc, lost_q.pop_front());
          chk("locked_when_lost", o_locked, 0);
        end
      end
      prev_lost = o_lost;
    end
  end

  initial begin
    int p;
    int h;
    hb  = 1'b0;
    rst = 1'b1;
    #2 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Ideal train: lock on rise 5.
    ideal(6);
    chk("locked_after_train", o_locked, 1);
    // One long period while locked, then relock.
    send_wave(105, 10, -1, -1);
    ideal(6);
    chk("relocked", o_locked, 1);
    // Tolerance edges.
    send_wave(98, 10, -1, -1);
    send_wave(102, 10, -1, -1);
    send_wave(97, 10, -1, -1);
    send_wave(103, 10, -1, -1);
    send_wave(100, 12, -1, -1);
    send_wave(100, 13, -1, -1);
    ideal(6);
    // Loss while locked; next rise clears o_lost without a measurement.
    send_wave(260, 10, -1, -1);
    send_wave(100, 10, -1, -1);
    chk("lost_cleared", o_lost, 0);
    chk("measure_after_lost", o_locked, 0);
    ideal(5);
    chk("relocked_after_lost", o_locked, 1);
    // Asynchronous reset mid-lock, then relock.
    send_wave(100, 10, -1, 50);
    ideal(6);
    chk("relocked_after_rst", o_locked, 1);
    // Short glitch mid-period.
    send_wave(100, 10, 50, -1);
    ideal(6);
    // Random trains around the nominal point.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 7) begin
        p = 98 + int'($urandom_range(0, 4));
        h = 8 + int'($urandom_range(0, 4));
      end else begin
        p = 95 + int'($urandom_range(0, 10));
        h = 7 + int'($urandom_range(0, 7));
      end
      send_wave(p, h, -1, -1);
    end
    ideal(1);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("lost_queue_drained", lost_q.size(), 0);
    chk("final_err_count", o_err_count, m_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
